// File: rtl/text_memory_engine_if.sv
// Host-side bundle for text_memory_engine: cell write port, command port and engine status.
// master = host that issues writes/commands, slave = the memory engine.
interface text_memory_engine_if #(
  parameter int X_W = 7,
  parameter int Y_W = 6,
  parameter int W   = 17
);
  logic           wr_valid;
  logic           wr_ready;
  logic [X_W-1:0] wr_x;
  logic [Y_W-1:0] wr_y;
  logic [W-1:0]   wr_value;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [W-1:0]   cmd_value;
  logic           busy;

  modport master (
    output wr_valid, wr_x, wr_y, wr_value, cmd_valid, cmd_op, cmd_value,
    input  wr_ready, cmd_ready, busy
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_value, cmd_valid, cmd_op, cmd_value,
    output wr_ready, cmd_ready, busy
  );
endinterface

// File: rtl/text_memory_engine.sv
// Text-cell attribute store with 1-cycle display read and a CLEAR/SCROLL_UP engine; optional TEXT_MEMORY_CURSOR_EN.
// Display port never stalls; host write/command are ready only while the engine is IDLE and not in reset.
module text_memory_engine #(
  parameter int COLS    = 100,
  parameter int ROWS    = 37,
  parameter int X_W     = 7,
  parameter int Y_W     = 6,
  parameter int CHAR_W  = 8,
  parameter int COLOR_W = 4,
  parameter int ADDR_W  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [X_W-1:0]     rd_x,
  input  logic [Y_W-1:0]     rd_y,
  output logic [CHAR_W-1:0]  charindex,
  output logic [COLOR_W-1:0] foreground,
  output logic [COLOR_W-1:0] background,
  output logic               blink,
`ifdef TEXT_MEMORY_CURSOR_EN
  input  logic [X_W-1:0]     cursor_x,
  input  logic [Y_W-1:0]     cursor_y,
  input  logic               cursor_enable,
  output logic               cursor,
`endif
  text_memory_engine_if.slave host
);

  localparam int W = CHAR_W + 2*COLOR_W + 1;
  localparam int N = COLS * ROWS;
  localparam logic [X_W:0]      COLS_X   = (X_W+1)'(COLS);
  localparam logic [Y_W:0]      ROWS_Y   = (Y_W+1)'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_SRC = ADDR_W'(COLS*(ROWS-1) - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SCROLL_RD, SCROLL_WR, SCROLL_FILL} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [W-1:0]      fill_dat;
  logic [W-1:0]      scroll_dat;
  logic [W-1:0]      rd_dat;
  logic [W-1:0]      mem [N];

  logic              idle, wr_acc, cmd_acc, wr_ok, rd_ok;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [W-1:0]      mem_wd;

  assign idle           = (state == IDLE);
  assign host.wr_ready  = idle && !reset;
  assign host.cmd_ready = idle && !reset;
  assign host.busy      = !idle;
  assign wr_acc         = host.wr_valid && host.wr_ready;
  assign cmd_acc        = host.cmd_valid && host.cmd_ready;

  assign wr_ok   = ({1'b0, host.wr_x} < COLS_X) && ({1'b0, host.wr_y} < ROWS_Y);
  assign rd_ok   = ({1'b0, rd_x} < COLS_X) && ({1'b0, rd_y} < ROWS_Y);
  assign wr_addr = ADDR_W'(host.wr_y) * COLS_A + ADDR_W'(host.wr_x);
  assign rd_addr = ADDR_W'(rd_y) * COLS_A + ADDR_W'(rd_x);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (cmd_acc) begin
          ptr_nxt = '0;
          if (host.cmd_op == 2'b01)
            state_nxt = CLEAR;
          else if (host.cmd_op == 2'b10)
            state_nxt = (ROWS == 1) ? SCROLL_FILL : SCROLL_RD;
        end
      end
      CLEAR, SCROLL_FILL: begin
        if (ptr == LAST_A) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      SCROLL_RD: state_nxt = SCROLL_WR;
      SCROLL_WR: begin
        // Pointer rolls straight into the first cell of the last row for the fill pass.
        ptr_nxt   = ptr + 1'b1;
        state_nxt = (ptr == LAST_SRC) ? SCROLL_FILL : SCROLL_RD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    unique case (state)
      IDLE: begin
        mem_we = wr_acc && wr_ok;
        mem_wa = wr_addr;
        mem_wd = host.wr_value;
      end
      CLEAR, SCROLL_FILL: begin
        mem_we = 1'b1;
        mem_wa = ptr;
        mem_wd = fill_dat;
      end
      SCROLL_WR: begin
        mem_we = 1'b1;
        mem_wa = ptr;
        mem_wd = scroll_dat;
      end
      default: mem_we = 1'b0;
    endcase
    // Reset halts the engine before it touches another cell.
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      fill_dat <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (cmd_acc) fill_dat <= host.cmd_value;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    if (state == SCROLL_RD) scroll_dat <= mem[ptr + COLS_A];
  end

  always_ff @(posedge clk) begin
    if (reset)
      rd_dat <= '0;
    else if (rd_ok)
      rd_dat <= mem[rd_addr];
    else
      rd_dat <= '0;
  end

  assign charindex  = rd_dat[CHAR_W-1:0];
  assign foreground = rd_dat[CHAR_W +: COLOR_W];
  assign background = rd_dat[CHAR_W+COLOR_W +: COLOR_W];
  assign blink      = rd_dat[W-1];

`ifdef TEXT_MEMORY_CURSOR_EN
  always_ff @(posedge clk) begin
    if (reset)
      cursor <= 1'b0;
    else
      cursor <= cursor_enable && (rd_x == cursor_x) && (rd_y == cursor_y);
  end
`endif

endmodule

// File: tb/tb_text_memory_engine.sv
// Directed bench for text_memory_engine at COLS=4, ROWS=3 with hand-computed expectations.
module tb_text_memory_engine;
  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int X_W  = 3;
  localparam int Y_W  = 2;
  localparam int W    = 17;

  logic           clk = 1'b0;
  logic           reset;
  logic [X_W-1:0] rd_x;
  logic [Y_W-1:0] rd_y;
  logic [7:0]     charindex;
  logic [3:0]     foreground, background;
  logic           blink;
  logic [W-1:0]   word;

  int checks = 0;
  int errors = 0;

  text_memory_engine_if #(.X_W(X_W), .Y_W(Y_W), .W(W)) host_if ();

  text_memory_engine #(
    .COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W),
    .CHAR_W(8), .COLOR_W(4), .ADDR_W(4)
  ) dut (
    .clk(clk), .reset(reset), .rd_x(rd_x), .rd_y(rd_y),
    .charindex(charindex), .foreground(foreground),
    .background(background), .blink(blink), .host(host_if)
  );

  always #5 clk = ~clk;
  assign word = {blink, background, foreground, charindex};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr_cell(input int x, input int y, input logic [W-1:0] v);
    host_if.wr_valid = 1'b1;
    host_if.wr_x     = X_W'(x);
    host_if.wr_y     = Y_W'(y);
    host_if.wr_value = v;
    tick();
    host_if.wr_valid = 1'b0;
  endtask

  task automatic rd_cell(input int x, input int y);
    rd_x = X_W'(x);
    rd_y = Y_W'(y);
    tick();
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [W-1:0] v);
    host_if.cmd_valid = 1'b1;
    host_if.cmd_op    = op;
    host_if.cmd_value = v;
    tick();
    host_if.cmd_valid = 1'b0;
  endtask

  // Counts busy cycles from just after the accept edge; also flags any wr_ready seen while busy.
  task automatic count_busy(output int cnt, output int rdy_seen);
    cnt = 0;
    rdy_seen = 0;
    while (host_if.busy && cnt < 60) begin
      if (host_if.wr_ready) rdy_seen++;
      cnt++;
      tick();
    end
  endtask

  initial begin
    int cnt, rdy_seen;
    reset = 1'b1;
    rd_x = '0;
    rd_y = '0;
    host_if.wr_valid  = 1'b0;
    host_if.wr_x      = '0;
    host_if.wr_y      = '0;
    host_if.wr_value  = '0;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = 2'b00;
    host_if.cmd_value = '0;
    tick();
    tick();
    chk("reset_word", 32'(word), 32'h0);
    chk("reset_busy", 32'(host_if.busy), 32'h0);
    chk("reset_wr_ready", 32'(host_if.wr_ready), 32'h0);
    reset = 1'b0;
    #1;
    chk("idle_wr_ready", 32'(host_if.wr_ready), 32'h1);
    chk("idle_cmd_ready", 32'(host_if.cmd_ready), 32'h1);

    for (int i = 0; i < COLS*ROWS; i++) wr_cell(i % COLS, i / COLS, 17'h00100 + 17'(i));

    // Basic write then read with field decode
    wr_cell(2, 1, 17'h1F241);
    rd_cell(2, 1);
    chk("rd_charindex", 32'(charindex), 32'h41);
    chk("rd_foreground", 32'(foreground), 32'h2);
    chk("rd_background", 32'(background), 32'hF);
    chk("rd_blink", 32'(blink), 32'h1);

    rd_cell(4, 0);
    chk("rd_oob_x", 32'(word), 32'h0);
    rd_cell(0, 3);
    chk("rd_oob_y", 32'(word), 32'h0);
    host_if.wr_valid = 1'b1;
    host_if.wr_x = 3'd4;
    host_if.wr_y = 2'd0;
    host_if.wr_value = 17'h1FFFF;
    #1;
    chk("oob_wr_ready", 32'(host_if.wr_ready), 32'h1);
    tick();
    host_if.wr_valid = 1'b0;
    rd_cell(0, 1);
    chk("oob_wr_discarded", 32'(word), 32'h00104);

    // NOP leaves the engine idle
    issue_cmd(2'b00, 17'h00033);
    chk("nop_busy", 32'(host_if.busy), 32'h0);
    issue_cmd(2'b11, 17'h00033);
    chk("reserved_busy", 32'(host_if.busy), 32'h0);

    issue_cmd(2'b01, 17'h00020);
    count_busy(cnt, rdy_seen);
    chk("clear_cycles", 32'(cnt), 32'd12);
    chk("clear_wr_ready_low", 32'(rdy_seen), 32'd0);
    for (int i = 0; i < COLS*ROWS; i++) begin
      rd_cell(i % COLS, i / COLS);
      chk($sformatf("clear_cell%0d", i), 32'(word), 32'h00020);
    end

    for (int i = 0; i < COLS*ROWS; i++)
      wr_cell(i % COLS, i / COLS, (i / COLS == 0) ? 17'h000AA : (i / COLS == 1) ? 17'h000BB : 17'h000CC);
    issue_cmd(2'b10, 17'h00020);
    count_busy(cnt, rdy_seen);
    chk("scroll_cycles", 32'(cnt), 32'd20);
    chk("scroll_wr_ready_low", 32'(rdy_seen), 32'd0);
    for (int i = 0; i < COLS*ROWS; i++) begin
      rd_cell(i % COLS, i / COLS);
      chk($sformatf("scroll_cell%0d", i), 32'(word),
          (i / COLS == 0) ? 32'h000BB : (i / COLS == 1) ? 32'h000CC : 32'h00020);
    end

    // Write and CLEAR offered together: both accepted, CLEAR wins afterwards
    rd_x = 3'd0;
    rd_y = 2'd0;
    host_if.wr_valid = 1'b1;
    host_if.wr_x = 3'd0;
    host_if.wr_y = 2'd0;
    host_if.wr_value = 17'h00055;
    host_if.cmd_valid = 1'b1;
    host_if.cmd_op = 2'b01;
    host_if.cmd_value = 17'h00000;
    #1;
    chk("sim_wr_ready", 32'(host_if.wr_ready), 32'h1);
    chk("sim_cmd_ready", 32'(host_if.cmd_ready), 32'h1);
    tick();
    host_if.wr_valid = 1'b0;
    host_if.cmd_valid = 1'b0;
    chk("sim_busy", 32'(host_if.busy), 32'h1);
    tick();
    chk("sim_write_visible", 32'(word), 32'h00055);
    count_busy(cnt, rdy_seen);
    chk("sim_clear_done", 32'(host_if.busy), 32'h0);
    rd_cell(0, 0);
    chk("sim_clear_wins", 32'(word), 32'h00000);

    // Reset part-way through CLEAR
    for (int i = 0; i < COLS*ROWS; i++) wr_cell(i % COLS, i / COLS, 17'h00100 + 17'(i));
    rd_x = 3'd3;
    rd_y = 2'd2;
    issue_cmd(2'b01, 17'h00077);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midreset_busy", 32'(host_if.busy), 32'h0);
    chk("midreset_wr_ready", 32'(host_if.wr_ready), 32'h1);
    chk("midreset_word", 32'(word), 32'h0);
    for (int i = 0; i < COLS*ROWS; i++) begin
      rd_cell(i % COLS, i / COLS);
      chk($sformatf("midreset_cell%0d", i), 32'(word),
          (i < 5) ? 32'h00077 : 32'h00100 + 32'(i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/text_memory_engine.md
Name: text_memory_engine

Overview:
Parametrised text-mode video memory, successor to the fixed 100-column character/attribute store. Holds one attribute word per text cell. Provides a registered display read port for the character generator and a host write port with a valid/ready handshake. Adds a command engine that performs hardware screen CLEAR and SCROLL_UP, so the host does not rewrite every cell.

Parameters:
COLS, 100, text columns
ROWS, 37, text rows
X_W, 7, column coordinate width (2^X_W >= COLS)
Y_W, 6, row coordinate width (2^Y_W >= ROWS)
CHAR_W, 8, character index width
COLOR_W, 4, colour field width
ADDR_W, 12, cell address width (2^ADDR_W >= COLS*ROWS)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-high reset
rd_x  in  X_W  display read column
rd_y  in  Y_W  display read row
charindex  out  CHAR_W  character index of the read cell
foreground  out  COLOR_W  foreground colour
background  out  COLOR_W  background colour
blink  out  1  blink attribute
wr_valid  in  1  host write request
wr_ready  out  1  host write accepted when high with wr_valid
wr_x  in  X_W  write column
wr_y  in  Y_W  write row
wr_value  in  W  attribute word, W = CHAR_W+2*COLOR_W+1
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_op  in  2  00 NOP, 01 CLEAR, 10 SCROLL_UP, 11 reserved (treated as NOP)
cmd_value  in  W  fill word for CLEAR and for the SCROLL_UP last row
busy  out  1  engine active

Behaviour:
- Word layout, LSB first: [CHAR_W-1:0] index; next COLOR_W bits foreground; next COLOR_W bits background; MSB blink.
- Cell address = y*COLS + x, computed at ADDR_W width with no truncation of intermediate results.
- Display read:
  - Latency 1. The outputs show the cell at the (rd_x, rd_y) sampled on the previous edge.
  - Out-of-range coordinates (x >= COLS or y >= ROWS) give an all-zero word.
  - Read-during-write to the same address returns the old data.
- Reset:
  - All outputs clear to 0; state returns to IDLE; busy=0.
  - Memory contents are not cleared; power-up contents are undefined.
- Reset mid-command: the engine stops at once and returns to IDLE. Cells already written stay written; busy=0 from the next cycle.
- Handshake:
  - wr_ready = cmd_ready = (state==IDLE) && !reset.
  - A write is accepted and committed on the same edge.
  - An out-of-range write is accepted and discarded.
- Simultaneous wr_valid and cmd_valid in IDLE: both are accepted. The write commits on that edge; the command starts on the next edge, so its effect overrides the write.
- States:
  - IDLE: accepted CLEAR -> CLEAR; accepted SCROLL_UP -> SCROLL_RD (or SCROLL_FILL if ROWS==1); NOP stays IDLE with busy=0.
  - CLEAR: pointer 0..COLS*ROWS-1, one write of cmd_value per cycle; after the last write -> IDLE.
  - SCROLL_RD: read cell at pointer+COLS -> SCROLL_WR.
  - SCROLL_WR: write that data at pointer. If pointer == COLS*(ROWS-1)-1 -> SCROLL_FILL; else pointer+1 -> SCROLL_RD.
  - SCROLL_FILL: write cmd_value (latched at accept) to the last row, one cell per cycle, then -> IDLE.
- busy is high in every state except IDLE.
- Cycle counts from the accept edge: CLEAR occupies N = COLS*ROWS cycles; SCROLL_UP occupies 2*(N-COLS)+COLS cycles.
- The display port is never stalled. During a command it shows the intermediate contents.

Optional Feature:
- Macro: TEXT_MEMORY_CURSOR_EN.
- When defined, the block adds:
  - inputs cursor_x [X_W], cursor_y [Y_W], cursor_enable [1];
  - output cursor [1], registered with the same latency 1 as the display outputs.
- cursor = 1 when cursor_enable=1 and the sampled (rd_x, rd_y) equals (cursor_x, cursor_y); reset value 0.
- When undefined, these ports and their logic are absent.

Test Plan:
- COLS=4, ROWS=3: write (x=2, y=1, 0x1_F2_41) -> read (2,1) one cycle later gives charindex=0x41, foreground=0x2, background=0xF, blink=1.
- Read (x=4, y=0) and (x=0, y=3) -> all outputs 0; a write to (4,0) is accepted and leaves address 4 unchanged.
- CLEAR with fill 0x00020 at COLS=4, ROWS=3 -> busy high for exactly 12 cycles; all 12 cells read 0x00020; wr_ready low throughout.
- Rows preloaded to 0x000AA, 0x000BB, 0x000CC; SCROLL_UP with fill 0x00020 -> busy for 20 cycles; rows then read BB, CC, 20.
- Simultaneous write (0,0)=0x00055 and CLEAR fill 0 -> both accepted; the cell reads 0x00055 at the next cycle and 0 after completion.
- Reset asserted at cycle 5 of CLEAR -> busy=0 and wr_ready=1 on the next cycle; cells 0..4 hold the fill, cells 5..11 keep their prior values.
